// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: MDOp encodings,
// FSM states and the MD-class hazard timing constants used by the control unit.
package md_sequencer_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MFHI  = 3'd4;
    localparam logic [2:0] MD_MFLO  = 3'd5;
    localparam logic [2:0] MD_MTHI  = 3'd6;
    localparam logic [2:0] MD_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // MD-class operands are consumed in E; MFHI/MFLO produce their value in E.
    localparam logic [1:0] MD_TUSE_RS = 2'd1;
    localparam logic [1:0] MD_TUSE_RT = 2'd1;
    localparam logic [1:0] MD_TNEW_MF = 2'd1;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_sequencer_arith.sv
// Combinational 64-bit multiply and 32-bit divide/remainder, signed or unsigned.
module md_arith (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_signed,
    output logic [63:0] o_prod,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_div_zero
);

    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;

    // The low 64 bits of the extended product are correct for both signednesses.
    assign w_ext_a = i_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
    assign w_ext_b = i_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
    assign o_prod  = w_ext_a * w_ext_b;

    // Divide on magnitudes so 0x80000000 / -1 cannot overflow or trap.
    assign w_neg_a    = i_signed & i_a[31];
    assign w_neg_b    = i_signed & i_b[31];
    assign w_mag_a    = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_mag_b    = w_neg_b ? (32'd0 - i_b) : i_b;
    assign o_div_zero = (i_b == 32'd0);
    assign w_den      = o_div_zero ? 32'd1 : w_mag_b;
    assign w_uquot    = w_mag_a / w_den;
    assign w_urem     = w_mag_a % w_den;
    assign o_quot     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uquot) : w_uquot;
    assign o_rem      = w_neg_a ? (32'd0 - w_urem) : w_urem;

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed-latency
// MULT/DIV with a countdown, and serves MFHI/MFLO/MTHI/MTLO.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    if (MULT_CYCLES == 0) begin : g_bad_mult_cycles
        $error("md_sequencer: MULT_CYCLES must be at least 1");
    end
    if (DIV_CYCLES == 0) begin : g_bad_div_cycles
        $error("md_sequencer: DIV_CYCLES must be at least 1");
    end

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_sh_hi;
    logic [31:0]      r_sh_lo;
    logic             r_sh_wr;

    logic [63:0]      w_prod;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic             w_div_zero;

    md_arith u_arith (
        .i_a        (A),
        .i_b        (B),
        .i_signed   (md_is_signed(MDOp)),
        .o_prod     (w_prod),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    // Sequencer FSM: result is captured at Start, committed to HI/LO on the last count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
            r_sh_wr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            MD_MULT, MD_MULTU: begin
                                r_sh_hi <= w_prod[63:32];
                                r_sh_lo <= w_prod[31:0];
                                r_sh_wr <= 1'b1;
                                r_cnt   <= CNT_W'(MULT_CYCLES);
                                r_busy  <= 1'b1;
                                r_state <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_sh_hi <= w_rem;
                                r_sh_lo <= w_quot;
                                r_sh_wr <= ~w_div_zero;
                                r_cnt   <= CNT_W'(DIV_CYCLES);
                                r_busy  <= 1'b1;
                                r_state <= ST_DIV;
                            end
                            MD_MTHI: r_hi <= A;
                            MD_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (r_sh_wr) begin
                            r_hi <= r_sh_hi;
                            r_lo <= r_sh_lo;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // MFHI/MFLO read port; any other op reads as zero.
    always_comb begin
        MDOut = 32'd0;
        case (MDOp)
            MD_MFHI: MDOut = r_hi;
            MD_MFLO: MDOut = r_lo;
            default: MDOut = 32'd0;
        endcase
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

`ifndef SYNTHESIS
    // Flags MD instructions that reach E while an operation is still in flight.
    always_ff @(posedge clk) begin
        if (reset_n && Start && r_busy) begin
            $warning("md_sequencer: Start ignored while busy (MDOp=%0d)", MDOp);
        end
    end
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: scoreboard of expected HI/LO/latency
// per operation, checked when Busy falls.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;
    logic        Busy1;
    logic [31:0] HI1;
    logic [31:0] LO1;
    logic [31:0] MDOut1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    md_sequencer u_dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
    );

    md_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .Busy(Busy1), .HI(HI1), .LO(LO1), .MDOut(MDOut1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; A = 32'd0; B = 32'd0;
    endtask

    task automatic wait_idle(inout int n);
        while (Busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_result(input int n);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got completion with no expected entry, required one entry");
        end else begin
            e = sb_q.pop_front();
            if (n !== e.cycles) begin
                bad++;
                $display("FAIL %s_busy_cycles: got %0d required %0d", e.name, n, e.cycles);
            end
            total++;
            if (HI !== e.hi) begin
                bad++;
                $display("FAIL %s_hi: got %h required %h", e.name, HI, e.hi);
            end
            total++;
            if (LO !== e.lo) begin
                bad++;
                $display("FAIL %s_lo: got %h required %h", e.name, LO, e.lo);
            end
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int cycles);
        int n;
        sb_q.push_back('{name, hi, lo, cycles});
        issue(op, a, b);
        n = 0;
        wait_idle(n);
        check_result(n);
    endtask

    // Reference model for the random mix, written from the ISA definition.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output int cyc);
        longint      sa;
        longint      sb;
        logic [63:0] r64;
        logic [63:0] q64;
        bit          sgn;
        sgn = (op == MD_MULT) || (op == MD_DIV);
        sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (op == MD_MULT || op == MD_MULTU) begin
            r64 = sa * sb;
            hi = r64[63:32]; lo = r64[31:0]; cyc = 5;
        end else if (b == 32'd0) begin
            hi = m_hi; lo = m_lo; cyc = 10;
        end else begin
            q64 = sa / sb;
            r64 = sa % sb;
            hi = r64[31:0]; lo = q64[31:0]; cyc = 10;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; Start = 1'b0; MDOp = MD_MFHI; A = 32'd0; B = 32'd0;
        #12;
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDOut !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h mdout=%h required all zero", Busy, HI, LO, MDOut);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_busy: got %b required 0", Busy);
        end
    endtask

    task automatic test_mult;
        run_op("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        MDOp = MD_MFHI; #1;
        total++;
        if (MDOut !== 32'h00000001) begin
            bad++;
            $display("FAIL mfhi_after_multu: got %h required %h", MDOut, 32'h00000001);
        end
        MDOp = MD_MFLO; #1;
        total++;
        if (MDOut !== 32'hFFFFFFFE) begin
            bad++;
            $display("FAIL mflo_after_multu: got %h required %h", MDOut, 32'hFFFFFFFE);
        end
    endtask

    task automatic test_div;
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    endtask

    task automatic test_mthi_mfhi;
        issue(MD_MTHI, 32'h12345678, 32'd0);
        Start = 1'b1; MDOp = MD_MFHI; #1;
        total++;
        if (MDOut !== 32'h12345678 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi_mfhi: got mdout=%h busy=%b required mdout=12345678 busy=0", MDOut, Busy);
        end
        @(posedge clk); #1;
        Start = 1'b0;
        total++;
        if (Busy !== 1'b0 || HI !== 32'h12345678 || LO !== m_lo) begin
            bad++;
            $display("FAIL mfhi_no_effect: got busy=%b hi=%h lo=%h required busy=0 hi=12345678 lo=%h", Busy, HI, LO, m_lo);
        end
        m_hi = 32'h12345678;
    endtask

    task automatic test_start_while_busy;
        int n;
        sb_q.push_back('{"div_busy_ignore", 32'd2, 32'd14, 10});
        issue(MD_DIV, 32'd100, 32'd7);
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            if (n == 3) begin Start = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd3; end
            if (n == 6) begin Start = 1'b1; MDOp = MD_MTHI; A = 32'hDEADBEEF; end
            @(posedge clk); #1;
            Start = 1'b0;
        end
        check_result(n);
        @(posedge clk); #1;
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_mult_started: got busy=%b required 0", Busy);
        end
    endtask

    task automatic test_reset_mid_div;
        issue(MD_DIV, 32'd1000, 32'd3);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b0; #1;
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL async_reset_mid_div: got busy=%b hi=%h lo=%h required all zero", Busy, HI, LO);
        end
        @(negedge clk); reset_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
        run_op("mult_after_reset", MD_MULT, 32'd4, 32'd5, 32'd0, 32'd20, 5);
    endtask

    task automatic test_div_overflow;
        run_op("div_overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        total++;
        if ($isunknown({HI, LO})) begin
            bad++;
            $display("FAIL div_overflow_x: got hi=%h lo=%h required no X", HI, LO);
        end
    endtask

    task automatic test_random_mix;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          cyc;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if (i == 5) b = 32'hFFFFFFF3;
            model_op(op, a, b, eh, el, cyc);
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, eh, el, cyc);
        end
    endtask

    task automatic test_one_cycle;
        int n;
        sb_q.push_back('{"mult_main_b2b", 32'd0, 32'd42, 5});
        issue(MD_MULT, 32'd6, 32'd7);
        total++;
        if (Busy1 !== 1'b1) begin
            bad++;
            $display("FAIL one_cycle_busy_high: got %b required 1", Busy1);
        end
        @(posedge clk); #1;
        total++;
        if (Busy1 !== 1'b0 || HI1 !== 32'd0 || LO1 !== 32'd42) begin
            bad++;
            $display("FAIL one_cycle_result: got busy=%b hi=%h lo=%h required busy=0 hi=0 lo=2a", Busy1, HI1, LO1);
        end
        n = 1;
        wait_idle(n);
        check_result(n);
        run_op("divu_b2b", MD_DIVU, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF, 10);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mfhi();
        test_start_while_busy();
        test_reset_mid_div();
        test_div_overflow();
        test_random_mix();
        test_one_cycle();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
